// File: rtl/sramlike_axi_bridge_if.sv
// AXI3 master-side bundle for the sram-like bridge: address, data and response
// channels grouped with master (bridge) and slave (interconnect) views.
interface sramlike_axi_bridge_if #(
    parameter int ID_W = 4
);
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [3:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sramlike_axi_bridge.sv
// Round-robin bridge from NUM_MASTERS sram-like channels to one AXI3 master port,
// one transaction in flight, INCR read bursts up to 16 beats, single-beat writes.
//
// state | meaning
// IDLE  | arbitrate, grant and latch a request
// AR    | read address presented, waiting for arready
// R     | streaming read beats to the owner until rlast
// AW_W  | write address and data presented, each retiring on its own handshake
// B     | waiting for the write response
module sramlike_axi_bridge #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_MASTERS-1:0]    req,
    input  logic [NUM_MASTERS-1:0]    wr,
    input  logic [2*NUM_MASTERS-1:0]  size,
    input  logic [32*NUM_MASTERS-1:0] addr,
    input  logic [32*NUM_MASTERS-1:0] wdata,
    input  logic [4*NUM_MASTERS-1:0]  len,
    output logic [NUM_MASTERS-1:0]    addr_ok,
    output logic [NUM_MASTERS-1:0]    data_ok,
    output logic [NUM_MASTERS-1:0]    data_last,
    output logic [31:0]               rdata_o,
    sramlike_axi_bridge_if.master     axi
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] gnt_q, gnt_d;
    logic [1:0]       size_q, size_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       len_q, len_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;

    logic             gnt_valid;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] next_ptr;
    logic             sel_wr;
    logic [1:0]       sel_size;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_len;
    logic             r_beat;
    logic             b_done;
    logic             unused_resp;

    assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

    // First asserted request at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!gnt_valid && req[i] && (((int'(rr_ptr_q) + k) % NUM_MASTERS) == i)) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = PTR_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_len   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_wr    = wr[i];
                sel_size  = size[2*i +: 2];
                sel_addr  = addr[32*i +: 32];
                sel_wdata = wdata[32*i +: 32];
                sel_len   = len[4*i +: 4];
            end
        end
    end

    assign next_ptr = (int'(gnt_q) == NUM_MASTERS - 1) ? '0 : gnt_q + PTR_W'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            len_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            len_q     <= len_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    gnt_d     = gnt_idx;
                    size_d    = sel_size;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    len_d     = sel_len;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = sel_wr ? S_AW_W : S_AR;
                end
            end
            S_AR: begin
                if (axi.arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (axi.rvalid && axi.rlast) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            S_AW_W: begin
                // A ready seen while its valid is already down is harmless: the flag is sticky.
                aw_done_d = aw_done_q | axi.awready;
                w_done_d  = w_done_q | axi.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (axi.bvalid) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign r_beat = (state_q == S_R) && axi.rvalid;
    assign b_done = (state_q == S_B) && axi.bvalid;

    always_comb begin
        addr_ok   = '0;
        data_ok   = '0;
        data_last = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            addr_ok[i]   = aresetn && (state_q == S_IDLE) && gnt_valid && (gnt_idx == PTR_W'(i));
            data_ok[i]   = (r_beat || b_done) && (gnt_q == PTR_W'(i));
            data_last[i] = ((r_beat && axi.rlast) || b_done) && (gnt_q == PTR_W'(i));
        end
        rdata_o = r_beat ? axi.rdata : 32'd0;

        axi.arid    = ID_W'(gnt_q);
        axi.araddr  = addr_q;
        axi.arlen   = len_q;
        axi.arsize  = {1'b0, size_q};
        axi.arburst = 2'b01;
        axi.arlock  = 2'b00;
        axi.arcache = 4'b0000;
        axi.arprot  = 3'b000;
        axi.arvalid = (state_q == S_AR);
        axi.rready  = (state_q == S_R);

        axi.awid    = ID_W'(gnt_q);
        axi.awaddr  = addr_q;
        axi.awlen   = 4'd0;
        axi.awsize  = {1'b0, size_q};
        axi.awburst = 2'b01;
        axi.awlock  = 2'b00;
        axi.awcache = 4'b0000;
        axi.awprot  = 3'b000;
        axi.awvalid = (state_q == S_AW_W) && !aw_done_q;

        axi.wid     = ID_W'(gnt_q);
        axi.wdata   = wdata_q;
        axi.wlast   = 1'b1;
        axi.wvalid  = (state_q == S_AW_W) && !w_done_q;
        unique case (size_q)
            2'd0:    axi.wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    axi.wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: axi.wstrb = 4'b1111;
        endcase
        axi.bready  = (state_q == S_B);
    end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench for sramlike_axi_bridge with three channels: randomized
// reads/writes against a small reference model of grants, strobes and beats.
module tb_sramlike_axi_bridge;

    localparam int NM  = 3;
    localparam int IDW = 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [NM-1:0]     req;
    logic [NM-1:0]     wr;
    logic [2*NM-1:0]   size;
    logic [32*NM-1:0]  addr;
    logic [32*NM-1:0]  wdata;
    logic [4*NM-1:0]   len;
    logic [NM-1:0]     addr_ok;
    logic [NM-1:0]     data_ok;
    logic [NM-1:0]     data_last;
    logic [31:0]       rdata_o;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_ptr_m = 0;

    always #5 aclk = ~aclk;

    sramlike_axi_bridge_if #(.ID_W(IDW)) axi ();

    sramlike_axi_bridge #(.NUM_MASTERS(NM), .ID_W(IDW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .len       (len),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .data_last (data_last),
        .rdata_o   (rdata_o),
        .axi       (axi.master)
    );

    function automatic logic [NM-1:0] onehot(input int i);
        return NM'(1) << i;
    endfunction

    function automatic int model_grant(input int r, input int ptr);
        for (int k = 0; k < NM; k++) begin
            int c;
            c = (ptr + k) % NM;
            if (((r >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    // Strobe = contiguous run of (1 << size) bytes, capped at the bus width, at the aligned lane.
    function automatic logic [3:0] ref_strb(input int sz, input int a);
        int nbytes, base;
        nbytes = (sz >= 2) ? 4 : (1 << sz);
        base   = ((a & 3) / nbytes) * nbytes;
        return 4'(((1 << nbytes) - 1) << base);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_chan(input int ch, input logic w, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] l);
        wr    = (wr & ~(NM'(1) << ch)) | (NM'(w) << ch);
        size  = (size & ~((2*NM)'(3) << (2*ch))) | ((2*NM)'(sz) << (2*ch));
        addr  = (addr & ~((32*NM)'(32'hFFFF_FFFF) << (32*ch))) | ((32*NM)'(a) << (32*ch));
        wdata = (wdata & ~((32*NM)'(32'hFFFF_FFFF) << (32*ch))) | ((32*NM)'(d) << (32*ch));
        len   = (len & ~((4*NM)'(15) << (4*ch))) | ((4*NM)'(l) << (4*ch));
    endtask

    task automatic finish_single_read_unchecked();
        tick();
        req = '0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b1;
        axi.rdata  = $urandom;
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        req = '1;
        tick();
        @(negedge aclk);
        n_checks++;
        if (addr_ok !== '0) begin n_fail++; $display("FAIL reset_addr_ok: got %b expected 000", addr_ok); end
        n_checks++;
        if ({data_ok, data_last} !== '0) begin n_fail++; $display("FAIL reset_data_ok: got %b/%b expected 0", data_ok, data_last); end
        n_checks++;
        if (rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
        n_checks++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_axi_valids: got %b expected 00000",
                     {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
        end
        req = '0;
        tick();
        aresetn = 1'b1;
        rr_ptr_m = 0;
        tick();
    endtask

    task automatic test_single_read();
        int g;
        logic [31:0] d;
        d = $urandom;
        set_chan(0, 1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 4'd0);
        req = 3'b001;
        g = model_grant(int'(req), rr_ptr_m);
        @(negedge aclk);
        n_checks++;
        if (addr_ok !== onehot(g)) begin n_fail++; $display("FAIL single_addr_ok: got %b expected %b", addr_ok, onehot(g)); end
        tick();
        req = '0;
        axi.arready = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arid, axi.arburst} !==
            {1'b1, 32'h1FC0_0000, 4'd0, 3'd2, IDW'(g), 2'b01}) begin
            n_fail++;
            $display("FAIL single_ar: got v=%b a=%h len=%0d size=%0d id=%0d burst=%b expected v=1 a=1fc00000 len=0 size=2 id=%0d burst=01",
                     axi.arvalid, axi.araddr, axi.arlen, axi.arsize, axi.arid, axi.arburst, g);
        end
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1;
        axi.rlast  = 1'b1;
        axi.rdata  = d;
        @(negedge aclk);
        n_checks++;
        if ({data_ok, data_last} !== {onehot(g), onehot(g)}) begin
            n_fail++; $display("FAIL single_data_ok: got %b/%b expected %b/%b", data_ok, data_last, onehot(g), onehot(g));
        end
        n_checks++;
        if (rdata_o !== d) begin n_fail++; $display("FAIL single_rdata: got %h expected %h", rdata_o, d); end
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        rr_ptr_m = (g + 1) % NM;
        @(negedge aclk);
        n_checks++;
        if ({axi.rready, axi.arvalid} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got rready/arvalid %b expected 00", {axi.rready, axi.arvalid}); end
        tick();
    endtask

    task automatic test_burst_read();
        int g, dly, gap, pulses;
        logic [31:0] a;
        logic [31:0] beats [8];
        a = $urandom & 32'hFFFF_FFC0;
        foreach (beats[b]) beats[b] = $urandom;
        set_chan(1, 1'b0, 2'd2, a, 32'd0, 4'd7);
        req = 3'b010;
        g = model_grant(int'(req), rr_ptr_m);
        @(negedge aclk);
        n_checks++;
        if (addr_ok !== onehot(g)) begin n_fail++; $display("FAIL burst_addr_ok: got %b expected %b", addr_ok, onehot(g)); end
        tick();
        req = '0;
        axi.arready = 1'b0;
        dly = $urandom_range(0, 2);
        @(negedge aclk);
        n_checks++;
        if ({axi.arvalid, axi.araddr, axi.arlen, axi.arid} !== {1'b1, a, 4'd7, IDW'(g)}) begin
            n_fail++;
            $display("FAIL burst_ar: got v=%b a=%h len=%0d id=%0d expected v=1 a=%h len=7 id=%0d",
                     axi.arvalid, axi.araddr, axi.arlen, axi.arid, a, g);
        end
        repeat (dly) tick();
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        pulses = 0;
        for (int b = 0; b < 8; b++) begin
            gap = $urandom_range(0, 2);
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            repeat (gap) begin
                @(negedge aclk);
                n_checks++;
                if (data_ok !== '0) begin n_fail++; $display("FAIL burst_gap_data_ok: got %b expected 000", data_ok); end
                tick();
            end
            axi.rvalid = 1'b1;
            axi.rlast  = (b == 7);
            axi.rdata  = beats[b];
            @(negedge aclk);
            if (data_ok === onehot(g)) pulses++;
            n_checks++;
            if (data_last !== ((b == 7) ? onehot(g) : NM'(0))) begin
                n_fail++; $display("FAIL burst_data_last beat %0d: got %b", b, data_last);
            end
            n_checks++;
            if (rdata_o !== beats[b]) begin n_fail++; $display("FAIL burst_rdata beat %0d: got %h expected %h", b, rdata_o, beats[b]); end
            tick();
        end
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        rr_ptr_m = (g + 1) % NM;
        n_checks++;
        if (pulses != 8) begin n_fail++; $display("FAIL burst_pulse_count: got %0d expected 8", pulses); end
        @(negedge aclk);
        n_checks++;
        if (axi.rready !== 1'b0) begin n_fail++; $display("FAIL burst_end_rready: got %b expected 0", axi.rready); end
        tick();
    endtask

    task automatic test_write_byte();
        int g;
        set_chan(0, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB, 4'd5);
        req = 3'b001;
        g = model_grant(int'(req), rr_ptr_m);
        @(negedge aclk);
        n_checks++;
        if (addr_ok !== onehot(g)) begin n_fail++; $display("FAIL wbyte_addr_ok: got %b expected %b", addr_ok, onehot(g)); end
        tick();
        req = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({axi.awvalid, axi.wvalid, axi.awlen, axi.awsize, axi.wlast, axi.awaddr} !==
            {2'b11, 4'd0, 3'd0, 1'b1, 32'h8000_0003}) begin
            n_fail++;
            $display("FAIL wbyte_aw: got v=%b%b len=%0d size=%0d wlast=%b a=%h expected v=11 len=0 size=0 wlast=1 a=80000003",
                     axi.awvalid, axi.wvalid, axi.awlen, axi.awsize, axi.wlast, axi.awaddr);
        end
        n_checks++;
        if (axi.wstrb !== ref_strb(0, 3)) begin n_fail++; $display("FAIL wbyte_wstrb: got %b expected %b", axi.wstrb, ref_strb(0, 3)); end
        n_checks++;
        if (axi.wdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL wbyte_wdata: got %h expected 000000ab", axi.wdata); end
        tick();
        axi.wready = 1'b0;
        repeat (2) begin
            @(negedge aclk);
            n_checks++;
            if ({axi.awvalid, axi.wvalid, data_ok} !== {2'b10, NM'(0)}) begin
                n_fail++; $display("FAIL wbyte_aw_wait: got aw/w=%b%b data_ok=%b expected 10/000", axi.awvalid, axi.wvalid, data_ok);
            end
            tick();
        end
        axi.awready = 1'b1;
        tick();
        axi.awready = 1'b0;
        @(negedge aclk);
        n_checks++;
        if ({axi.bready, axi.awvalid, axi.wvalid, data_ok} !== {3'b100, NM'(0)}) begin
            n_fail++; $display("FAIL wbyte_b_wait: got bready=%b aw/w=%b%b data_ok=%b expected 1/00/000", axi.bready, axi.awvalid, axi.wvalid, data_ok);
        end
        tick();
        axi.bvalid = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({data_ok, data_last} !== {onehot(g), onehot(g)}) begin
            n_fail++; $display("FAIL wbyte_resp: got %b/%b expected %b/%b", data_ok, data_last, onehot(g), onehot(g));
        end
        tick();
        axi.bvalid = 1'b0;
        rr_ptr_m = (g + 1) % NM;
    endtask

    task automatic test_write_random();
        for (int it = 0; it < 6; it++) begin
            int ch, g, da, dw, cyc;
            logic [1:0]  sz;
            logic [31:0] a, d;
            logic aw_pend, w_pend;
            ch = $urandom_range(0, NM - 1);
            sz = (it == 0) ? 2'd1 : 2'($urandom_range(0, 3));
            a  = $urandom;
            if (it == 0) a = (a & 32'hFFFF_FFFC) | 32'd2;
            d  = $urandom;
            da = (it == 1) ? 0 : $urandom_range(0, 3);
            dw = (it == 1) ? 0 : $urandom_range(0, 3);
            set_chan(ch, 1'b1, sz, a, d, 4'($urandom));
            req = onehot(ch);
            g = model_grant(int'(req), rr_ptr_m);
            @(negedge aclk);
            n_checks++;
            if (addr_ok !== onehot(g)) begin n_fail++; $display("FAIL wrand_addr_ok it %0d: got %b expected %b", it, addr_ok, onehot(g)); end
            tick();
            req = '0;
            aw_pend = 1'b1;
            w_pend  = 1'b1;
            cyc = 0;
            while ((aw_pend || w_pend) && cyc < 10) begin
                axi.awready = (cyc >= da);
                axi.wready  = (cyc >= dw);
                @(negedge aclk);
                n_checks++;
                if ({axi.awvalid, axi.wvalid} !== {aw_pend, w_pend}) begin
                    n_fail++; $display("FAIL wrand_valids it %0d cyc %0d: got %b%b expected %b%b", it, cyc, axi.awvalid, axi.wvalid, aw_pend, w_pend);
                end
                if (cyc == 0) begin
                    n_checks++;
                    if ({axi.wstrb, axi.awsize, axi.awid, axi.wid, axi.wdata} !==
                        {ref_strb(int'(sz), int'(a)), {1'b0, sz}, IDW'(g), IDW'(g), d}) begin
                        n_fail++;
                        $display("FAIL wrand_fields it %0d: got strb=%b size=%0d id=%0d/%0d data=%h expected strb=%b size=%0d id=%0d data=%h",
                                 it, axi.wstrb, axi.awsize, axi.awid, axi.wid, axi.wdata, ref_strb(int'(sz), int'(a)), sz, g, d);
                    end
                end
                tick();
                if (axi.awready) aw_pend = 1'b0;
                if (axi.wready)  w_pend  = 1'b0;
                cyc++;
            end
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            axi.bvalid  = 1'b1;
            @(negedge aclk);
            n_checks++;
            if ({data_ok, data_last} !== {onehot(g), onehot(g)}) begin
                n_fail++; $display("FAIL wrand_resp it %0d: got %b/%b expected %b/%b", it, data_ok, data_last, onehot(g), onehot(g));
            end
            tick();
            axi.bvalid = 1'b0;
            rr_ptr_m = (g + 1) % NM;
        end
    endtask

    task automatic test_contention();
        int order [4] = '{0, 1, 2, 0};
        logic [31:0] d;
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        rr_ptr_m = 0;
        for (int c = 0; c < NM; c++) set_chan(c, 1'b0, 2'd2, $urandom & 32'hFFFF_FFFC, 32'd0, 4'd0);
        req = '1;
        for (int t = 0; t < 4; t++) begin
            @(negedge aclk);
            n_checks++;
            if (addr_ok !== onehot(order[t])) begin n_fail++; $display("FAIL contend_grant %0d: got %b expected %b", t, addr_ok, onehot(order[t])); end
            tick();
            axi.arready = 1'b1;
            @(negedge aclk);
            n_checks++;
            if ({addr_ok, axi.arid} !== {NM'(0), IDW'(order[t])}) begin
                n_fail++; $display("FAIL contend_ar %0d: got addr_ok=%b arid=%0d expected 000/%0d", t, addr_ok, axi.arid, order[t]);
            end
            tick();
            d = $urandom;
            axi.arready = 1'b0;
            axi.rvalid  = 1'b1;
            axi.rlast   = 1'b1;
            axi.rdata   = d;
            @(negedge aclk);
            n_checks++;
            if ({addr_ok, data_ok, rdata_o} !== {NM'(0), onehot(order[t]), d}) begin
                n_fail++; $display("FAIL contend_r %0d: got addr_ok=%b data_ok=%b rdata=%h expected 000/%b/%h", t, addr_ok, data_ok, rdata_o, onehot(order[t]), d);
            end
            tick();
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            rr_ptr_m = (order[t] + 1) % NM;
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        int g;
        logic [31:0] d;
        set_chan(0, 1'b0, 2'd2, 32'h0000_1000, 32'd0, 4'd7);
        req = 3'b001;
        g = model_grant(int'(req), rr_ptr_m);
        @(negedge aclk);
        n_checks++;
        if (addr_ok !== onehot(g)) begin n_fail++; $display("FAIL rstmid_addr_ok: got %b expected %b", addr_ok, onehot(g)); end
        tick();
        req = '0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            axi.rvalid = 1'b1;
            axi.rlast  = 1'b0;
            axi.rdata  = $urandom;
            @(negedge aclk);
            n_checks++;
            if (data_ok !== onehot(g)) begin n_fail++; $display("FAIL rstmid_beat %0d: got %b expected %b", b, data_ok, onehot(g)); end
            if (b < 2) tick();
        end
        #1;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({addr_ok, data_ok, data_last, rdata_o} !== '0) begin
            n_fail++; $display("FAIL rstmid_outputs: got addr_ok=%b data_ok=%b last=%b rdata=%h expected all 0", addr_ok, data_ok, data_last, rdata_o);
        end
        n_checks++;
        if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_axi: got %b expected 00000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
        end
        axi.rvalid = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        rr_ptr_m = 0;
        set_chan(2, 1'b0, 2'd2, 32'h0000_2000, 32'd0, 4'd0);
        req = 3'b101;
        g = model_grant(int'(req), rr_ptr_m);
        @(negedge aclk);
        n_checks++;
        if (addr_ok !== onehot(g)) begin n_fail++; $display("FAIL rstmid_ptr_restart: got %b expected %b", addr_ok, onehot(g)); end
        finish_single_read_unchecked();
        rr_ptr_m = (g + 1) % NM;
        req = 3'b100;
        g = model_grant(int'(req), rr_ptr_m);
        @(negedge aclk);
        n_checks++;
        if (addr_ok !== onehot(g)) begin n_fail++; $display("FAIL rstmid_ch2_grant: got %b expected %b", addr_ok, onehot(g)); end
        tick();
        req = '0;
        axi.arready = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (axi.arid !== IDW'(g)) begin n_fail++; $display("FAIL rstmid_ch2_arid: got %0d expected %0d", axi.arid, g); end
        tick();
        d = $urandom;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rlast   = 1'b1;
        axi.rdata   = d;
        @(negedge aclk);
        n_checks++;
        if ({data_ok, data_last, rdata_o} !== {onehot(g), onehot(g), d}) begin
            n_fail++; $display("FAIL rstmid_ch2_r: got %b/%b/%h expected %b/%b/%h", data_ok, data_last, rdata_o, onehot(g), onehot(g), d);
        end
        tick();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        rr_ptr_m = (g + 1) % NM;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        req = '0; wr = '0; size = '0; addr = '0; wdata = '0; len = '0;
        axi.arready = 1'b0;
        axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;
        axi.awready = 1'b0;
        axi.wready = 1'b0;
        axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;
        test_reset();
        test_single_read();
        test_burst_read();
        test_write_byte();
        test_write_random();
        test_contention();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sramlike_axi_bridge.md
# sramlike_axi_bridge

Parametrised bridge between NUM_MASTERS sram-like request channels (I-cache, D-cache, uncached path) and a single AXI3 master port. It replaces the fixed two-channel, single-beat bridge. It adds round-robin arbitration across any number of channels and INCR read bursts of up to 16 beats for cache-line refill. One transaction is in flight at a time; it sits between the caches and the top-level AXI pins of mycpu_top.

## Interface
- NUM_MASTERS, 2: number of sram-like channels; channel i occupies slice i of every packed port.
- ID_W, 4: AXI ID width; arid/awid carry the granted channel index, zero-extended.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- req  in  NUM_MASTERS  per-channel request.
- wr  in  NUM_MASTERS  1 = write.
- size  in  2*NUM_MASTERS  0 = byte, 1 = half, 2 = word.
- addr  in  32*NUM_MASTERS  byte address.
- wdata  in  32*NUM_MASTERS  write data.
- len  in  4*NUM_MASTERS  read beats minus 1; ignored for writes, which are always single-beat.
- addr_ok  out  NUM_MASTERS  request accepted.
- data_ok  out  NUM_MASTERS  read beat valid, or write response received.
- data_last  out  NUM_MASTERS  qualifies data_ok on the final read beat and on the write response.
- rdata_o  out  32  read data shared by all channels; valid only with the owner's data_ok.
- AXI3 channels ar*, r*, aw*, w*, b*: standard widths as at the mycpu_top boundary; IDs are ID_W wide.

## Operation
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE:
  - Grant g is the first asserted req at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - addr_ok[g] is asserted combinationally in the same cycle.
  - Latch wr, size, addr, wdata, len and g.
  - Next state is AR if wr = 0, otherwise AW_W.
- AR: arvalid = 1, araddr = latched addr, arlen = latched len, arsize = {0, size}, arburst = 2'b01, arid = g. On arready, go to R.
- R:
  - rready = 1.
  - Each rvalid pulses data_ok[g] with rdata_o = rdata.
  - On rlast, also assert data_last[g]; go to IDLE and set rr_ptr to (g+1) mod NUM_MASTERS.
- AW_W:
  - awvalid and wvalid are raised together; each drops independently after its own handshake.
  - awlen = 0, wlast = 1, wdata = latched wdata, awsize = {0, size}.
  - wstrb decoding: size 0 gives 4'b0001 << addr[1:0]; size 1 gives 4'b1100 if addr[1], else 4'b0011; size 2 or 3 gives 4'b1111.
  - Go to B once both handshakes are done (same-cycle or either order).
- B: bready = 1. On bvalid, pulse data_ok[g] and data_last[g]; go to IDLE and advance rr_ptr.
- Constant outputs: ar/aw lock, cache and prot = 0; burst = 2'b01; wid = awid.
- rresp, bresp, rid and bid are ignored.
- A req on a non-granted channel is held off (no addr_ok) until the bridge returns to IDLE.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - All valid/ready outputs are 0; addr_ok, data_ok and data_last are 0.
  - Latched registers and rdata_o are 0.
- Minimum read latency: addr_ok in cycle 0; arvalid in cycle 1; with arready in cycle 1, the first data_ok is in cycle 2 provided rvalid is high.
- data_ok and rdata_o follow rvalid/rdata combinationally, with no buffering.
- Minimum write latency: AW/W in cycle 1; data_ok in cycle 2 when the handshakes and bvalid all arrive on the earliest cycles.
- Back-to-back: the cycle after the last beat or bvalid is IDLE, and the next grant can be issued in that cycle.
- Reset mid-transaction drops all valids immediately. Any outstanding AXI response is the interconnect's concern, since the interconnect is reset together with the bridge.
- req deasserted after addr_ok has no effect; the latched transaction completes.

## Test plan
- Single read, channel 0, addr 0x1FC0_0000, len 0. Required: arlen 0, arid 0, arsize 2; one data_ok[0] and data_last[0] with rdata_o = slave data.
- Burst read, channel 1, len 7, with rvalid gaps. Required: arlen 7, arid 1; exactly 8 data_ok[1] pulses, in order; data_last[1] only on the 8th.
- Byte write at addr 0x...03, data 0xAB, size 0. Required: wstrb 4'b1000 and awlen 0. Also cover half-word writes at addr[1] = 1, which require wstrb 4'b1100. With awready delayed 3 cycles after wready, data_ok comes only after bvalid.
- Contention with NUM_MASTERS = 3, all req held high. Required grant order 0, 1, 2, 0; no addr_ok to any non-granted channel while busy.
- Reset asserted during R, on the 3rd of 8 beats. Required: all outputs return to reset values immediately; after release, a new request from channel 2 is granted with rr_ptr restarting at 0.
